rgb_sinp: RTL and testbench
===========================

RGB_SINP -- requirements
Module: rgb_sinp

Interface
REQ-001 SHALL provide parameter CLKS_MIN_HIGH, default 10: a high pulse shorter than this many clocks is a glitch and is ignored.
REQ-002 SHALL provide parameter CLKS_BIT_THRESH, default 58: a high pulse shorter than this decodes as bit "0", otherwise as bit "1".
REQ-003 SHALL provide parameter CLKS_MAX_HIGH, default 150: a high pulse longer than this is a frame error.
REQ-004 SHALL provide parameter CLKS_STR_RST, default 4800: low for this many clocks (50 us at 96 MHz) is a stream-reset.
REQ-005 SHALL provide parameter COUNTER_MAX, default 5000: sets the pulse counter width, $clog2(COUNTER_MAX+1).
REQ-006 SHALL provide port clk, input, 1: 96 MHz clock, synchronous with the FIFO w_clk.
REQ-007 SHALL provide port rst_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL provide port in_sig, input, 1: WS2812b serial line, asynchronous to clk.
REQ-009 SHALL provide port in_wr_fifo_full, input, 1: FIFO full flag.
REQ-010 SHALL provide port out_wr_fifo_en, output, 1: one-clock write strobe.
REQ-011 SHALL provide port out_wr_fifo_data, output, 32: word written to the FIFO.
REQ-012 SHALL provide port out_overflow, output, 1: sticky flag, a word was dropped because the FIFO was full.
REQ-013 SHALL provide port out_frame_err, output, 1: sticky flag, a glitch, over-long high, or partial word was discarded.

Function
REQ-014 SHALL pass in_sig through a 2-FF synchronizer; all edge detection and timing SHALL use the synchronized value only.
REQ-015 SHALL implement states S_LOW (count low time), S_HIGH (count high time) and S_WAIT_LOW (discard until line low).
REQ-016 S_LOW, synchronized rising edge: clear the counter, go to S_HIGH.
REQ-017 S_LOW, counter reaches CLKS_STR_RST-1 while the stream-reset flag is armed:
- emit a stream-reset word;
- discard any partial bits, and set out_frame_err if 1-23 bits were pending;
- clear the flag;
- saturate the counter and stay in S_LOW.
REQ-018 S_HIGH, synchronized falling edge with count < CLKS_MIN_HIGH: treat as a glitch, set out_frame_err, do not change the bit count, return to S_LOW.
REQ-019 S_HIGH, falling edge with CLKS_MIN_HIGH <= count < CLKS_BIT_THRESH: shift in "0"; with count >= CLKS_BIT_THRESH: shift in "1"; then S_LOW with the counter cleared.
REQ-020 S_HIGH, count exceeds CLKS_MAX_HIGH: set out_frame_err, discard the partial word, go to S_WAIT_LOW.
REQ-021 S_WAIT_LOW, synchronized low: go to S_LOW with the counter cleared.
REQ-022 Bit order SHALL be MSB first, G7..G0 then R7..R0 then B7..B0, shifted into a 24-bit register.
REQ-023 On the 24th bit, the block SHALL emit data word {1'b1, 1'b0, 6'b0, G, R, B} and clear the bit count to 0.
REQ-024 Stream-reset word SHALL be 32'hC000_0000; bit31 = valid, bit30 = stream_reset.
REQ-025 The stream-reset flag SHALL be armed at reset and on every accepted bit (REQ-019), so each idle period emits at most one stream-reset word.
REQ-026 Emit timing: out_wr_fifo_en and out_wr_fifo_data SHALL be registered and valid in the clock after the decision cycle, for exactly one clock.
REQ-027 If in_wr_fifo_full is 1 in the decision cycle:
- out_wr_fifo_en SHALL stay 0;
- the word SHALL be dropped;
- out_overflow SHALL be set;
- decoding SHALL continue unaffected.
REQ-028 out_wr_fifo_data SHALL hold its last value when out_wr_fifo_en is 0.
REQ-029 A data emit and a stream-reset emit SHALL never occur in the same cycle, because they are mutually exclusive by state.
REQ-030 Arithmetic: the counter SHALL saturate at COUNTER_MAX and never wrap.

Reset
REQ-031 While rst_n = 0, asynchronously:
- state = S_LOW, counter = 0, bit count = 0, shift register = 0;
- synchronizer FFs = 0;
- stream-reset flag armed;
- out_wr_fifo_en = 0, out_wr_fifo_data = 0, out_overflow = 0, out_frame_err = 0.
REQ-032 Reset asserted mid-word SHALL discard the partial word without emitting anything.
REQ-033 Decoding SHALL resume on the first synchronized rising edge after rst_n deasserts.

Verification
REQ-034 Reset, then in_sig low for 5000 clk -> exactly one write of 32'hC000_0000, 4800-4803 clk after rst_n rises; no second write.
REQ-035 24 bits encoding G=8'hA5, R=8'h3C, B=8'h0F (T0H 38 / T0L 82, T1H 77 / T1L 43 clk), then low for 5000 clk -> write 32'h80A5_3C0F, then 32'hC000_0000.
REQ-036 in_wr_fifo_full = 1 during the 24th bit, 3 frames sent -> 2 data writes, out_overflow = 1, the third frame's data correct.
REQ-037 5-clk high glitch inside a frame -> out_frame_err = 1, the following 24 valid bits decode correctly.
REQ-038 200-clk high after 10 bits, then a full valid frame -> out_frame_err = 1, only the valid frame is written.
REQ-039 rst_n pulsed low after 12 bits, then a valid frame -> no write for the partial frame, the valid frame is written correctly.

Source files
------------

// File: rtl/rgb_sinp.sv
// WS2812b serial-line decoder: measures high/low pulse widths on a synchronized
// input and writes decoded GRB pixel words and stream-reset markers to a FIFO.
module rgb_sinp #(
  parameter int unsigned CLKS_MIN_HIGH   = 10,
  parameter int unsigned CLKS_BIT_THRESH = 58,
  parameter int unsigned CLKS_MAX_HIGH   = 150,
  parameter int unsigned CLKS_STR_RST    = 4800,
  parameter int unsigned COUNTER_MAX     = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_sig,
  input  logic        in_wr_fifo_full,
  output logic        out_wr_fifo_en,
  output logic [31:0] out_wr_fifo_data,
  output logic        out_overflow,
  output logic        out_frame_err
);

  localparam int unsigned CW  = $clog2(COUNTER_MAX + 1);
  localparam int unsigned BCW = 5;
  localparam int unsigned SW  = 24;
  localparam int unsigned DW  = 32;

  localparam logic [DW-1:0] STR_RST_WORD = 32'hC000_0000;

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_HIGH     = 2'd1,
    S_WAIT_LOW = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]   shift_q, shift_d;
  logic            armed_q, armed_d;
  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            prev_q, prev_d;
  logic            wr_en_q, wr_en_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic            ovf_q, ovf_d;
  logic            ferr_q, ferr_d;

  logic            rise;
  logic            bit_val;
  logic            emit;
  logic [DW-1:0]   emit_word;

  assign out_wr_fifo_en   = wr_en_q;
  assign out_wr_fifo_data = wr_data_q;
  assign out_overflow     = ovf_q;
  assign out_frame_err    = ferr_q;

  // Pulse-width FSM, bit assembly and FIFO write decision
  always_comb begin
    sync1_d   = in_sig;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    armed_d   = armed_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
    ovf_d     = ovf_q;
    ferr_d    = ferr_q;
    emit      = 1'b0;
    emit_word = STR_RST_WORD;
    bit_val   = 1'b0;

    rise    = sync2_q & ~prev_q;
    cnt_inc = (cnt_q == CW'(COUNTER_MAX)) ? cnt_q : cnt_q + CW'(1);

    case (state_q)
      S_LOW: begin
        if (rise) begin
          cnt_d   = '0;
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_inc;
          if (armed_q && (cnt_q == CW'(CLKS_STR_RST - 1))) begin
            emit      = 1'b1;
            emit_word = STR_RST_WORD;
            if (bit_cnt_q != '0) ferr_d = 1'b1;
            bit_cnt_d = '0;
            shift_d   = '0;
            armed_d   = 1'b0;
          end
        end
      end
      S_HIGH: begin
        if (!sync2_q) begin
          state_d = S_LOW;
          cnt_d   = '0;
          if (cnt_q < CW'(CLKS_MIN_HIGH)) begin
            ferr_d = 1'b1;
          end else begin
            bit_val = (cnt_q >= CW'(CLKS_BIT_THRESH));
            shift_d = (shift_q << 1) | SW'(bit_val);
            armed_d = 1'b1;
            if (bit_cnt_q == BCW'(SW - 1)) begin
              emit      = 1'b1;
              emit_word = {8'h80, shift_d};
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + BCW'(1);
            end
          end
        end else if (cnt_q > CW'(CLKS_MAX_HIGH)) begin
          ferr_d    = 1'b1;
          bit_cnt_d = '0;
          shift_d   = '0;
          state_d   = S_WAIT_LOW;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_WAIT_LOW: begin
        if (!sync2_q) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase

    // A full FIFO drops the word but never stalls decoding
    if (emit) begin
      if (in_wr_fifo_full) begin
        ovf_d = 1'b1;
      end else begin
        wr_en_d   = 1'b1;
        wr_data_d = emit_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LOW;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      armed_q   <= 1'b1;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      armed_q   <= armed_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      ovf_q     <= ovf_d;
      ferr_q    <= ferr_d;
    end
  end

endmodule

// File: tb/tb_rgb_sinp.sv
// Bench for rgb_sinp: pulse-level decoding model feeding an expected-write queue,
// a per-cycle output monitor, and literal checks for each directed scenario.
module tb_rgb_sinp;

  localparam int MIN_H = 10;
  localparam int THR   = 58;
  localparam int MAX_H = 150;
  localparam int STR   = 4800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_sig = 1'b0;
  logic        in_wr_fifo_full = 1'b0;
  logic        out_wr_fifo_en;
  logic [31:0] out_wr_fifo_data;
  logic        out_overflow;
  logic        out_frame_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int first_wr_cyc = -1;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] last_data = '0;
  logic        prev_en = 1'b0;

  logic [23:0] m_sh;
  int          m_n;
  bit          m_armed;
  bit          m_ferr;
  bit          m_ovf;

  rgb_sinp dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_sig           (in_sig),
    .in_wr_fifo_full  (in_wr_fifo_full),
    .out_wr_fifo_en   (out_wr_fifo_en),
    .out_wr_fifo_data (out_wr_fifo_data),
    .out_overflow     (out_overflow),
    .out_frame_err    (out_frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Every write is matched against the model queue; idle cycles must hold data
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      last_data = '0;
      prev_en   = 1'b0;
    end else begin
      if (out_wr_fifo_en) begin
        check("en_single_clk", 32'(prev_en), 32'd0);
        if (got_q.size() == 0) first_wr_cyc = cyc;
        got_q.push_back(out_wr_fifo_data);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write got=%h exp=none", out_wr_fifo_data);
        end else begin
          check("wr_data", out_wr_fifo_data, exp_q.pop_front());
        end
        last_data = out_wr_fifo_data;
      end else begin
        check("data_hold", out_wr_fifo_data, last_data);
      end
      prev_en = out_wr_fifo_en;
    end
  end

  function automatic logic [31:0] got_at(input int i);
    if (i < got_q.size()) return got_q[i];
    return 'x;
  endfunction

  // Pulse-level model: one call per high pulse / long low period
  task automatic model_high(input int h, input bit full);
    if (h < MIN_H) begin
      m_ferr = 1;
    end else if (h > MAX_H) begin
      m_ferr = 1;
      m_n = 0;
    end else begin
      m_sh = {m_sh[22:0], (h >= THR) ? 1'b1 : 1'b0};
      m_n++;
      m_armed = 1;
      if (m_n == 24) begin
        m_n = 0;
        if (full) m_ovf = 1;
        else exp_q.push_back({8'h80, m_sh});
      end
    end
  endtask

  task automatic model_low(input int l);
    if (l > STR && m_armed) begin
      if (m_n != 0) m_ferr = 1;
      m_n = 0;
      m_armed = 0;
      exp_q.push_back(32'hC000_0000);
    end
  endtask

  task automatic hold(input logic v, input int n);
    in_sig = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input bit full);
    int h;
    int l;
    h = b ? 77 : 38;
    l = b ? 43 : 82;
    in_wr_fifo_full = full;
    model_high(h, full);
    hold(1'b1, h);
    hold(1'b0, l);
    in_wr_fifo_full = 1'b0;
  endtask

  task automatic send_bits(input logic [23:0] w, input int hi, input int lo, input bit full24);
    for (int i = hi; i >= lo; i--) send_bit(w[i], full24 && (i == 0));
  endtask

  task automatic pulse_high(input int h);
    model_high(h, 0);
    hold(1'b1, h);
    hold(1'b0, 80);
  endtask

  task automatic idle(input int n);
    model_low(n);
    hold(1'b0, n);
  endtask

  task automatic do_reset();
    in_sig = 1'b0;
    in_wr_fifo_full = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_en", 32'(out_wr_fifo_en), 32'd0);
    check("rst_data", out_wr_fifo_data, 32'd0);
    check("rst_ovf", 32'(out_overflow), 32'd0);
    check("rst_ferr", 32'(out_frame_err), 32'd0);
    m_sh = '0; m_n = 0; m_armed = 1; m_ferr = 0; m_ovf = 0;
    got_q.delete();
    first_wr_cyc = -1;
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic end_scenario(input string name);
    repeat (10) @(negedge clk);
    check({name, "_ferr"}, 32'(out_frame_err), 32'(m_ferr));
    check({name, "_ovf"}, 32'(out_overflow), 32'(m_ovf));
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    @(negedge clk);

    // Idle line after reset: one stream-reset word, then silence
    do_reset();
    idle(5000);
    checks++;
    if (first_wr_cyc - rel_cyc < 4800 || first_wr_cyc - rel_cyc > 4803) begin
      failures++;
      $display("FAIL sr_latency got=%0d exp=4800..4803", first_wr_cyc - rel_cyc);
    end
    idle(5000);
    end_scenario("idle");
    check("idle_writes", 32'(got_q.size()), 32'd1);
    check("idle_word", got_at(0), 32'hC000_0000);

    // Single frame followed by stream reset
    do_reset();
    send_bits(24'hA53C0F, 23, 0, 0);
    idle(5000);
    end_scenario("frame");
    check("frame_word", got_at(0), 32'h80A5_3C0F);
    check("frame_sr", got_at(1), 32'hC000_0000);

    // FIFO full on the 24th bit of the middle frame
    do_reset();
    send_bits(24'h123456, 23, 0, 0);
    send_bits(24'hABCDEF, 23, 0, 1);
    send_bits(24'h0F1E2D, 23, 0, 0);
    idle(5000);
    end_scenario("full");
    check("full_writes", 32'(got_q.size()), 32'd3);
    check("full_w0", got_at(0), 32'h8012_3456);
    check("full_w1", got_at(1), 32'h800F_1E2D);
    check("full_ovf_lit", 32'(out_overflow), 32'd1);

    // Short glitch inside a frame leaves the bit count untouched
    do_reset();
    send_bits(24'h5AC396, 23, 14, 0);
    pulse_high(5);
    send_bits(24'h5AC396, 13, 0, 0);
    send_bits(24'h0FF081, 23, 0, 0);
    idle(5000);
    end_scenario("glitch");
    check("glitch_w0", got_at(0), 32'h805A_C396);
    check("glitch_w1", got_at(1), 32'h800F_F081);
    check("glitch_ferr_lit", 32'(out_frame_err), 32'd1);

    // Over-long high discards the partial word
    do_reset();
    send_bits(24'h13579B, 23, 14, 0);
    pulse_high(200);
    send_bits(24'h2468AC, 23, 0, 0);
    idle(5000);
    end_scenario("long");
    check("long_writes", 32'(got_q.size()), 32'd2);
    check("long_w0", got_at(0), 32'h8024_68AC);
    check("long_ferr_lit", 32'(out_frame_err), 32'd1);

    // Reset mid-word drops the partial frame
    do_reset();
    send_bits(24'hFEDCBA, 23, 12, 0);
    check("midrst_nowrite", 32'(got_q.size()), 32'd0);
    do_reset();
    send_bits(24'h112233, 23, 0, 0);
    idle(5000);
    end_scenario("midrst");
    check("midrst_writes", 32'(got_q.size()), 32'd2);
    check("midrst_w0", got_at(0), 32'h8011_2233);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
